// File: rtl/sig_acq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sig_acq_pkg
// Purpose  : Shared widths, edge-select encodings and timestamp word layout
//            for the signal acquisition path.
// Revision : 1.0 - initial release
// ============================================================================
package sig_acq_pkg;

    localparam int TS_CNT_W = 28;
    localparam int EPOCH_W  = 8;
    localparam int TS_W     = 37;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_sel_e;

    // Timestamp word: {pol, epoch, count}
    localparam int TS_CNT_LSB   = 0;
    localparam int TS_EPOCH_LSB = TS_CNT_W;
    localparam int TS_POL_BIT   = TS_CNT_W + EPOCH_W;

    function automatic logic [TS_W-1:0] pack_ts(
        input logic                pol,
        input logic [EPOCH_W-1:0]  epoch,
        input logic [TS_CNT_W-1:0] cnt
    );
        return {pol, epoch, cnt};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ts_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ts_fifo
// Purpose  : Synchronous first-word-fall-through FIFO with flush.
// Revision : 1.0 - initial release
// ============================================================================
module ts_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_wr_en,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_rd_en,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wptr;
    logic [c_AW:0]    r_rptr;
    logic             w_full;
    logic             w_empty;
    logic             w_rd;
    logic             w_wr;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                     (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);

    // A read in the same cycle frees the slot, so a full FIFO still accepts
    assign w_rd = i_rd_en & ~w_empty & ~i_flush;
    assign w_wr = i_wr_en & ~i_flush & (~w_full | w_rd);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + (c_AW+1)'(1);
            if (w_rd) r_rptr <= r_rptr + (c_AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[c_AW-1:0]] <= i_wr_data;
    end

    assign o_rd_data = w_empty ? '0 : r_mem[r_rptr[c_AW-1:0]];
    assign o_full    = w_full;
    assign o_empty   = w_empty;
    assign o_level   = r_wptr - r_rptr;

endmodule
`default_nettype wire

// File: rtl/edge_timestamp.sv
`default_nettype none
// ============================================================================
// Module   : edge_timestamp
// Purpose  : Time-stamps selected edges of an async signal with the 28-bit
//            timer count plus wrap epoch; flags loss of signal.
// Revision : 1.0 - initial release
// ============================================================================
module edge_timestamp
    import sig_acq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 8,
    parameter int LOST_TICKS  = 100
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         sig_in,
    input  logic [1:0]                   edge_sel,
    input  logic [TS_CNT_W-1:0]          tmr_count,
    input  logic                         tmr_10ms,
    output logic [TS_W-1:0]              ts_data,
    output logic                         ts_valid,
    input  logic                         ts_ready,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         overflow,
    output logic                         sig_lost
);

    localparam int                  c_LOST_W = $clog2(LOST_TICKS + 1);
    localparam logic [c_LOST_W-1:0] c_LOST   = c_LOST_W'(LOST_TICKS);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   r_msb;
    logic [EPOCH_W-1:0]     r_epoch;
    logic                   r_overflow;
    logic [c_LOST_W-1:0]    r_lost_cnt;

    logic                   w_sync;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_hit;
    logic                   w_wrap;
    logic [EPOCH_W-1:0]     w_epoch_now;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_rd;

    // Synchronizer and history flops are deliberately untouched by clr
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
            r_hist <= 1'b0;
            r_msb  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_hist <= r_sync[SYNC_STAGES-1];
            r_msb  <= tmr_count[TS_CNT_W-1];
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_rise = w_sync & ~r_hist;
    assign w_fall = ~w_sync & r_hist;
    assign w_hit  = (w_rise & edge_sel[0]) | (w_fall & edge_sel[1]);

    // Fold a same-cycle wrap into the stamp so epoch and count stay coherent
    assign w_wrap      = r_msb & ~tmr_count[TS_CNT_W-1];
    assign w_epoch_now = r_epoch + EPOCH_W'(w_wrap);

    assign w_rd = ts_valid & ts_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_epoch    <= '0;
            r_overflow <= 1'b0;
            r_lost_cnt <= '0;
        end else if (clr) begin
            r_epoch    <= '0;
            r_overflow <= 1'b0;
            r_lost_cnt <= '0;
        end else begin
            r_epoch <= w_epoch_now;
            if (w_hit && w_full && !w_rd) r_overflow <= 1'b1;
            if (w_rise || w_fall)
                r_lost_cnt <= '0;
            else if (tmr_10ms && (r_lost_cnt != c_LOST))
                r_lost_cnt <= r_lost_cnt + c_LOST_W'(1);
        end
    end

    ts_fifo #(
        .WIDTH (TS_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (clr),
        .i_wr_en   (w_hit),
        .i_wr_data (pack_ts(w_rise, w_epoch_now, tmr_count)),
        .i_rd_en   (ts_ready),
        .o_rd_data (ts_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (fifo_level)
    );

    assign ts_valid = ~w_empty;
    assign overflow = r_overflow;
    assign sig_lost = (r_lost_cnt == c_LOST);

endmodule
`default_nettype wire

// File: tb/tb_edge_timestamp.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_timestamp
// Purpose  : Directed self-checking bench for edge_timestamp with a
//            queue-based reference model compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_edge_timestamp;

    localparam int SYNC  = 2;
    localparam int DEPTH = 8;
    localparam int LOST  = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        sig_in = 1'b0;
    logic [1:0]  edge_sel = 2'b00;
    logic [27:0] tmr_count = '0;
    logic        tmr_10ms = 1'b0;
    logic        ts_ready = 1'b0;
    logic [36:0] ts_data;
    logic        ts_valid;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic        sig_lost;

    edge_timestamp #(
        .SYNC_STAGES (SYNC),
        .FIFO_DEPTH  (DEPTH),
        .LOST_TICKS  (LOST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .sig_in     (sig_in),
        .edge_sel   (edge_sel),
        .tmr_count  (tmr_count),
        .tmr_10ms   (tmr_10ms),
        .ts_data    (ts_data),
        .ts_valid   (ts_valid),
        .ts_ready   (ts_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .sig_lost   (sig_lost)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit ramp    = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: expected FIFO contents, epoch, sticky flag, tick count
    logic [36:0] exp_q[$];
    bit          samp[$];
    int          m_epoch = 0;
    int          m_lost  = 0;
    bit          m_ovf   = 1'b0;
    bit          m_msb   = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q.delete();
            samp.delete();
            for (int i = 0; i < SYNC + 2; i++) samp.push_back(1'b0);
            m_epoch = 0;
            m_lost  = 0;
            m_ovf   = 1'b0;
            m_msb   = 1'b0;
        end else begin
            bit s_new, s_old, rise, fall, wrap, hit, rd, full;
            int ep;
            samp.push_front(sig_in);
            s_new = samp[SYNC];
            s_old = samp[SYNC + 1];
            void'(samp.pop_back());
            rise  = s_new & !s_old;
            fall  = !s_new & s_old;
            wrap  = m_msb & !tmr_count[27];
            m_msb = tmr_count[27];
            hit   = (rise & edge_sel[0]) | (fall & edge_sel[1]);
            if (clr) begin
                exp_q.delete();
                m_epoch = 0;
                m_ovf   = 1'b0;
                m_lost  = 0;
            end else begin
                ep   = (m_epoch + int'(wrap)) % 256;
                rd   = (exp_q.size() > 0) && ts_ready;
                full = (exp_q.size() == DEPTH);
                if (rd) void'(exp_q.pop_front());
                if (hit) begin
                    if (!full || rd) exp_q.push_back({rise, 8'(ep), tmr_count});
                    else m_ovf = 1'b1;
                end
                m_epoch = ep;
                if (rise || fall) m_lost = 0;
                else if (tmr_10ms && m_lost < LOST) m_lost++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_valid", 64'(ts_valid), 64'(0));
            check("rst_level", 64'(fifo_level), 64'(0));
            check("rst_data", 64'(ts_data), 64'(0));
        end else begin
            check("valid", 64'(ts_valid), 64'(exp_q.size() != 0));
            check("level", 64'(fifo_level), 64'(exp_q.size()));
            check("overflow", 64'(overflow), 64'(m_ovf));
            check("sig_lost", 64'(sig_lost), 64'(m_lost == LOST));
            if (exp_q.size() != 0) check("data", 64'(ts_data), 64'(exp_q[0]));
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
        if (ramp) tmr_count = tmr_count + 28'd1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            tmr_10ms = 1'b1;
            cyc();
            tmr_10ms = 1'b0;
            cyc();
        end
    endtask

    logic [27:0] c0;
    logic [36:0] w0, w1;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst = 1'b0;
        repeat (3) cyc();
        check("lit_reset_valid", 64'(ts_valid), 64'(0));
        check("lit_reset_ovf", 64'(overflow), 64'(0));
        check("lit_reset_lost", 64'(sig_lost), 64'(0));
        rst = 1'b1;
        repeat (2) cyc();

        // Single rising edge with ramping timer
        ramp = 1'b1; tmr_count = 28'd100; edge_sel = 2'b01;
        cyc();
        sig_in = 1'b1; c0 = tmr_count;
        cyc();
        cyc();
        check("lit_latency_early", 64'(ts_valid), 64'(0));
        cyc();
        check("lit_latency_valid", 64'(ts_valid), 64'(1));
        check("lit_rise_word", 64'(ts_data), 64'({1'b1, 8'd0, 28'(c0 + 28'd2)}));
        ts_ready = 1'b1; cyc(); ts_ready = 1'b0;

        // Wrap coincident with a falling hit
        ramp = 1'b0; edge_sel = 2'b10; sig_in = 1'b0; tmr_count = 28'hFFFFFFF;
        cyc(); cyc();
        tmr_count = 28'd0;
        cyc();
        check("lit_wrap_word", 64'(ts_data), 64'({1'b0, 8'd1, 28'd0}));
        ts_ready = 1'b1; cyc(); ts_ready = 1'b0;
        edge_sel = 2'b11; sig_in = 1'b1; tmr_count = 28'd5;
        repeat (3) cyc();
        check("lit_epoch1_word", 64'(ts_data), 64'({1'b1, 8'd1, 28'd5}));
        ts_ready = 1'b1; cyc(); ts_ready = 1'b0;
        for (int i = 0; i < 255; i++) begin
            tmr_count = 28'h8000000; cyc();
            tmr_count = 28'd0;       cyc();
        end
        sig_in = 1'b0; tmr_count = 28'd7;
        repeat (3) cyc();
        check("lit_epoch_rollover", 64'(ts_data), 64'({1'b0, 8'd0, 28'd7}));
        ts_ready = 1'b1; cyc(); ts_ready = 1'b0;

        // Overflow, then a write accepted while full because of a read
        ramp = 1'b1;
        for (int i = 0; i < 9; i++) begin
            sig_in = ~sig_in; cyc();
        end
        repeat (3) cyc();
        check("lit_ovf_level", 64'(fifo_level), 64'(8));
        check("lit_ovf_flag", 64'(overflow), 64'(1));
        sig_in = ~sig_in; cyc(); cyc();
        ts_ready = 1'b1; cyc(); ts_ready = 1'b0;
        check("lit_full_rw_level", 64'(fifo_level), 64'(8));
        ts_ready = 1'b1; repeat (8) cyc(); ts_ready = 1'b0;
        check("lit_drained", 64'(fifo_level), 64'(0));

        // Loss detection
        ramp = 1'b0;
        tick_n(99);
        check("lit_lost_99", 64'(sig_lost), 64'(0));
        tmr_10ms = 1'b1; cyc(); tmr_10ms = 1'b0;
        check("lit_lost_100", 64'(sig_lost), 64'(1));
        cyc();
        edge_sel = 2'b00;
        sig_in = ~sig_in; cyc();
        sig_in = ~sig_in; cyc(); cyc();
        check("lit_none_clears_lost", 64'(sig_lost), 64'(0));
        cyc(); cyc();
        check("lit_none_no_word", 64'(fifo_level), 64'(0));
        tick_n(5);
        sig_in = ~sig_in; cyc(); cyc();
        tmr_10ms = 1'b1; cyc(); tmr_10ms = 1'b0;
        tick_n(99);
        check("lit_tick_edge_99", 64'(sig_lost), 64'(0));
        tmr_10ms = 1'b1; cyc(); tmr_10ms = 1'b0;
        check("lit_tick_edge_100", 64'(sig_lost), 64'(1));

        // Both edges from a one-clock pulse
        edge_sel = 2'b11; ramp = 1'b1; sig_in = 1'b0;
        repeat (4) cyc();
        ts_ready = 1'b1; repeat (2) cyc(); ts_ready = 1'b0;
        sig_in = 1'b1; cyc();
        sig_in = 1'b0; cyc();
        repeat (3) cyc();
        check("lit_pulse_level", 64'(fifo_level), 64'(2));
        w0 = ts_data;
        ts_ready = 1'b1; cyc(); ts_ready = 1'b0;
        w1 = ts_data;
        check("lit_pulse_pol0", 64'(w0[36]), 64'(1));
        check("lit_pulse_pol1", 64'(w1[36]), 64'(0));
        check("lit_pulse_spacing", 64'(w1[27:0] - w0[27:0]), 64'(1));
        ts_ready = 1'b1; cyc(); ts_ready = 1'b0;

        // Clear mid-stream with coincident hit; overflow is still set here
        ramp = 1'b0;
        tmr_count = 28'h8000000; cyc();
        tmr_count = 28'd0; cyc();
        ramp = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sig_in = ~sig_in; cyc();
        end
        repeat (3) cyc();
        check("lit_clr_pre_level", 64'(fifo_level), 64'(5));
        sig_in = ~sig_in; cyc(); cyc();
        clr = 1'b1; cyc(); clr = 1'b0;
        check("lit_clr_level", 64'(fifo_level), 64'(0));
        check("lit_clr_ovf", 64'(overflow), 64'(0));
        cyc();
        check("lit_clr_no_word", 64'(ts_valid), 64'(0));
        ramp = 1'b0; tmr_count = 28'd9; sig_in = ~sig_in;
        repeat (3) cyc();
        check("lit_clr_epoch0", 64'(ts_data), 64'({sig_in, 8'd0, 28'd9}));
        ts_ready = 1'b1; cyc(); ts_ready = 1'b0;

        // Asynchronous reset during a read
        ramp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sig_in = ~sig_in; cyc();
        end
        repeat (3) cyc();
        ts_ready = 1'b1; cyc();
        #2 rst = 1'b0;
        #1;
        check("lit_arst_valid", 64'(ts_valid), 64'(0));
        check("lit_arst_level", 64'(fifo_level), 64'(0));
        check("lit_arst_data", 64'(ts_data), 64'(0));
        check("lit_arst_ovf", 64'(overflow), 64'(0));
        check("lit_arst_lost", 64'(sig_lost), 64'(0));
        cyc();
        rst = 1'b1; ts_ready = 1'b0;
        repeat (5) cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
